// File: rtl/gen_stream_pkg.sv
// Shared types for the generator stream drain: FSM states, coordinate record and
// counter width, plus the saturating increment both run counters use.
package gen_stream_pkg;

    // Coordinate field width; the drain's WIDTH parameter is expected to match it.
    localparam int COORD_W = 32;
    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        DRAIN,
        FLUSH
    } drain_state_e;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
    } coord_t;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/gen_stream_drain_fifo.sv
// Small synchronous FIFO of coordinates with a fall-through head; the caller never
// pushes when full nor pops when empty.
module coord_fifo
    import gen_stream_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  coord_t                 push_data,
    input  logic                   pop,
    output coord_t                 head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    coord_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // NOTE: storage is deliberately left out of reset; only pointers and count are
    // cleared, and nothing downstream looks at head while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PW + 1)'(DEPTH));

endmodule

// File: rtl/gen_stream_drain.sv
// Launches a coordinate generator with latched arguments, buffers its samples,
// clips them to the framebuffer and issues pixel writes while tracking run counts.
module gen_stream_drain
    import gen_stream_pkg::*;
#(
    parameter int WIDTH      = COORD_W,
    parameter int FB_W       = 64,
    parameter int FB_H       = 64,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(FB_W * FB_H)
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic signed [WIDTH-1:0] cmd_a0,
    input  logic signed [WIDTH-1:0] cmd_a1,
    input  logic signed [WIDTH-1:0] cmd_a2,
    output logic                    gen_start,
    output logic signed [WIDTH-1:0] gen_a0,
    output logic signed [WIDTH-1:0] gen_a1,
    output logic signed [WIDTH-1:0] gen_a2,
    output logic                    gen_ready,
    input  logic                    gen_valid,
    input  logic                    gen_done,
    input  logic signed [WIDTH-1:0] gen_0,
    input  logic signed [WIDTH-1:0] gen_1,
    output logic                    fb_we,
    output logic [AW-1:0]           fb_addr,
    input  logic                    fb_stall,
    output logic                    busy,
    output logic                    run_done,
    output logic [COUNT_W-1:0]      pixel_count,
    output logic [COUNT_W-1:0]      clip_count
);

    localparam int XW = $clog2(FB_W);
    localparam int YW = $clog2(FB_H);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    drain_state_e  state;
    coord_t        in_coord;
    coord_t        head;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic          in_range;

    assign in_coord = '{x: gen_0, y: gen_1};
    assign gen_ready = (state == DRAIN) && !fifo_full;
    assign push      = gen_valid && gen_ready;

    coord_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (_clock),
        .rst      (_reset),
        .push     (push),
        .push_data(in_coord),
        .pop      (pop),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    // The write side runs in every state so FLUSH simply waits for it to drain.
    assign head_valid = !fifo_empty;
    assign in_range   = ($signed(head.x) >= 0) && ($signed(head.x) < FB_W) &&
                        ($signed(head.y) >= 0) && ($signed(head.y) < FB_H);
    assign fb_we      = head_valid && in_range;
    assign fb_addr    = fb_we ? {head.y[YW-1:0], head.x[XW-1:0]} : '0;
    assign pop        = head_valid && (!in_range || !fb_stall);

    assign cmd_ready = (state == IDLE) && !_reset;
    assign busy      = (state != IDLE);

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state       <= IDLE;
            gen_start   <= 1'b0;
            run_done    <= 1'b0;
            gen_a0      <= '0;
            gen_a1      <= '0;
            gen_a2      <= '0;
            pixel_count <= '0;
            clip_count  <= '0;
        end else begin
            // NOTE: pulses default low here so any set below lasts exactly one cycle.
            gen_start <= 1'b0;
            run_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= LAUNCH;
                        gen_start <= 1'b1;
                        gen_a0    <= cmd_a0;
                        gen_a1    <= cmd_a1;
                        gen_a2    <= cmd_a2;
                    end
                end
                LAUNCH: state <= DRAIN;
                DRAIN: begin
                    if (gen_done && gen_ready) state <= FLUSH;
                end
                FLUSH: begin
                    if (fifo_count == '0) begin
                        state    <= IDLE;
                        run_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (state == LAUNCH) begin
                pixel_count <= '0;
                clip_count  <= '0;
            end else begin
                if (fb_we && !fb_stall) pixel_count <= sat_inc(pixel_count);
                if (pop && !in_range)   clip_count  <= sat_inc(clip_count);
            end
        end
    end

endmodule
